// File: rtl/q_ram_row_reader_pkg.sv
// Shared constants, state encoding and address helper for the Q_RAM row readback engine.
// Row r of a matrix starts at word address r*MATRIX_DIM.
package q_ram_row_reader_pkg;
   localparam int WORD_LEN   = 16;
   localparam int MATRIX_DIM = 8;
   localparam int ADDR_BITS  = 7;
   localparam int ROW_W      = WORD_LEN * MATRIX_DIM;
   localparam int IDX_W      = $clog2(MATRIX_DIM);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_DIM - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      STREAM,
      DONE
   } state_t;

   function automatic logic [ADDR_BITS-1:0] row_base(input logic [IDX_W-1:0] row);
      return ADDR_BITS'(row) * ADDR_BITS'(MATRIX_DIM);
   endfunction
endpackage

// File: rtl/q_ram_row_reader_row_serializer.sv
// Holds one captured Q_RAM row (real and imag) and emits it column 0 first under valid/ready.
// Outputs hold after the final column so the bubble between rows shows stable values.
module q_ram_row_reader_row_serializer
   import q_ram_row_reader_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                load,
   input  logic [ROW_W-1:0]    real_row,
   input  logic [ROW_W-1:0]    imag_row,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [WORD_LEN-1:0] out_real,
   output logic [WORD_LEN-1:0] out_imag,
   output logic [IDX_W-1:0]    out_col,
   output logic                row_end
);
   logic [ROW_W-1:0] real_sh_reg;
   logic [ROW_W-1:0] imag_sh_reg;
   logic [ROW_W-1:0] real_shifted;
   logic [ROW_W-1:0] imag_shifted;
   logic [IDX_W-1:0] col_reg;
   logic             valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < MATRIX_DIM; gi++) begin : g_shift
         if (gi < MATRIX_DIM - 1) begin : g_mid
            assign real_shifted[gi*WORD_LEN +: WORD_LEN] = real_sh_reg[(gi+1)*WORD_LEN +: WORD_LEN];
            assign imag_shifted[gi*WORD_LEN +: WORD_LEN] = imag_sh_reg[(gi+1)*WORD_LEN +: WORD_LEN];
         end else begin : g_top
            assign real_shifted[gi*WORD_LEN +: WORD_LEN] = '0;
            assign imag_shifted[gi*WORD_LEN +: WORD_LEN] = '0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         real_sh_reg <= '0;
         imag_sh_reg <= '0;
         col_reg     <= '0;
         valid_reg   <= 1'b0;
      end else if (load) begin
         real_sh_reg <= real_row;
         imag_sh_reg <= imag_row;
         col_reg     <= '0;
         valid_reg   <= 1'b1;
      end else if (valid_reg && out_ready) begin
         if (col_reg == LAST_IDX) begin
            valid_reg <= 1'b0;
         end else begin
            real_sh_reg <= real_shifted;
            imag_sh_reg <= imag_shifted;
            col_reg     <= col_reg + IDX_W'(1);
         end
      end
   end

   assign out_valid = valid_reg;
   assign out_real  = real_sh_reg[WORD_LEN-1:0];
   assign out_imag  = imag_sh_reg[WORD_LEN-1:0];
   assign out_col   = col_reg;
   assign row_end   = (col_reg == LAST_IDX);
endmodule

// File: rtl/q_ram_row_reader.sv
// Reads one Q_RAM matrix (M1 or M2) row by row and streams its complex elements in row-major order.
// The FSM owns addressing, bank selection and completion; the serializer owns the per-row beats.
module q_ram_row_reader
   import q_ram_row_reader_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bank_sel,
   input  logic                 abort,
   output logic [ADDR_BITS-1:0] Dir_M1,
   output logic [ADDR_BITS-1:0] Dir_M2,
   input  logic [ROW_W-1:0]     Br_m1,
   input  logic [ROW_W-1:0]     Bi_m1,
   input  logic [ROW_W-1:0]     Br_m2,
   input  logic [ROW_W-1:0]     Bi_m2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_LEN-1:0]  out_real,
   output logic [WORD_LEN-1:0]  out_imag,
   output logic [IDX_W-1:0]     out_row,
   output logic [IDX_W-1:0]     out_col,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);
   state_t               state_reg, state_next;
   logic [IDX_W-1:0]     row_reg, row_next;
   logic                 bank_reg, bank_next;
   logic [ADDR_BITS-1:0] dir_m1_reg, dir_m1_next;
   logic [ADDR_BITS-1:0] dir_m2_reg, dir_m2_next;
   logic                 load, flush, beat, row_end;

   assign beat = out_valid && out_ready;

   always_comb begin
      state_next  = state_reg;
      row_next    = row_reg;
      bank_next   = bank_reg;
      dir_m1_next = dir_m1_reg;
      dir_m2_next = dir_m2_reg;
      load        = 1'b0;
      flush       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !abort) begin
               bank_next  = bank_sel;
               row_next   = '0;
               state_next = ISSUE;
            end
         end
         ISSUE:  state_next = WAIT;
         WAIT: begin
            load       = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            if (beat && row_end) begin
               if (row_reg == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  row_next   = row_reg + IDX_W'(1);
                  state_next = ISSUE;
                  if (bank_reg) dir_m2_next = row_base(row_reg + IDX_W'(1));
                  else          dir_m1_next = row_base(row_reg + IDX_W'(1));
               end
            end
         end
         DONE: begin
            state_next  = IDLE;
            row_next    = '0;
            dir_m1_next = '0;
            dir_m2_next = '0;
            flush       = 1'b1;
         end
         default: state_next = IDLE;
      endcase
      // Abort wins over any beat acceptance and leaves every output at its idle value.
      if (abort && state_reg != IDLE) begin
         state_next  = IDLE;
         row_next    = '0;
         bank_next   = 1'b0;
         dir_m1_next = '0;
         dir_m2_next = '0;
         load        = 1'b0;
         flush       = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         row_reg    <= '0;
         bank_reg   <= 1'b0;
         dir_m1_reg <= '0;
         dir_m2_reg <= '0;
      end else begin
         state_reg  <= state_next;
         row_reg    <= row_next;
         bank_reg   <= bank_next;
         dir_m1_reg <= dir_m1_next;
         dir_m2_reg <= dir_m2_next;
      end
   end

   q_ram_row_reader_row_serializer u_row_serializer (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (load),
      .real_row  (bank_reg ? Br_m2 : Br_m1),
      .imag_row  (bank_reg ? Bi_m2 : Bi_m1),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_col   (out_col),
      .row_end   (row_end)
   );

   assign Dir_M1   = dir_m1_reg;
   assign Dir_M2   = dir_m2_reg;
   assign out_row  = row_reg;
   assign out_last = out_valid && row_end && (row_reg == LAST_IDX);
   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == DONE);
endmodule

// File: tb/tb_q_ram_row_reader.sv
// Scoreboard bench for q_ram_row_reader: a Q_RAM model feeds the row buses, expected elements are
// queued at start and a negedge monitor pops and compares every accepted beat.
module tb_q_ram_row_reader;
   import q_ram_row_reader_pkg::*;

   localparam int N_EL = MATRIX_DIM * MATRIX_DIM;

   typedef logic [2*WORD_LEN+2*IDX_W:0] beat_t;   // {real, imag, row, col, last}

   logic                 clk = 1'b0;
   logic                 rst, start, bank_sel, abort, out_ready;
   logic [ADDR_BITS-1:0] Dir_M1, Dir_M2;
   logic [ROW_W-1:0]     Br_m1, Bi_m1, Br_m2, Bi_m2;
   logic                 out_valid, out_last, busy, done;
   logic [WORD_LEN-1:0]  out_real, out_imag;
   logic [IDX_W-1:0]     out_row, out_col;

   logic [WORD_LEN-1:0]  m1_re [N_EL];
   logic [WORD_LEN-1:0]  m1_im [N_EL];
   logic [WORD_LEN-1:0]  m2_re [N_EL];
   logic [WORD_LEN-1:0]  m2_im [N_EL];

   beat_t exp_q [$];
   int    tests = 0;
   int    fails = 0;
   int    beats = 0;
   int    done_cnt = 0;
   bit    rnd_ready = 1'b0;
   bit    exp_bank = 1'b0;
   bit    seen_valid = 1'b0;
   bit    stalled_prev = 1'b0;
   beat_t snap;
   time   first_valid_t, done_t, t0;
   int    d0;

   q_ram_row_reader dut (
      .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel), .abort(abort),
      .Dir_M1(Dir_M1), .Dir_M2(Dir_M2),
      .Br_m1(Br_m1), .Bi_m1(Bi_m1), .Br_m2(Br_m2), .Bi_m2(Bi_m2),
      .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Q_RAM model: the row starting at the registered address appears one clock later.
   always @(posedge clk) begin
      for (int k = 0; k < MATRIX_DIM; k++) begin
         Br_m1[k*WORD_LEN +: WORD_LEN] <= m1_re[(int'(Dir_M1) + k) % N_EL];
         Bi_m1[k*WORD_LEN +: WORD_LEN] <= m1_im[(int'(Dir_M1) + k) % N_EL];
         Br_m2[k*WORD_LEN +: WORD_LEN] <= m2_re[(int'(Dir_M2) + k) % N_EL];
         Bi_m2[k*WORD_LEN +: WORD_LEN] <= m2_im[(int'(Dir_M2) + k) % N_EL];
      end
   end

   always @(posedge clk) begin
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected element per accepted beat and checks stall stability.
   always @(negedge clk) begin
      beat_t cur, e;
      logic [IDX_W-1:0] e_row;
      cur = {out_real, out_imag, out_row, out_col, out_last};
      if (rst || abort) begin
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev)
            check("stall_hold", 64'({out_valid, cur}), 64'({1'b1, snap}));
         if (out_valid && !seen_valid) begin
            seen_valid    = 1'b1;
            first_valid_t = $time;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(beats), 64'(-1));
            end else begin
               e = exp_q.pop_front();
               check("beat", 64'(cur), 64'(e));
               e_row = e[2*IDX_W:IDX_W+1];
               check("dir_sel", 64'(exp_bank ? Dir_M2 : Dir_M1), 64'(int'(e_row) * MATRIX_DIM));
               check("dir_unsel", 64'(exp_bank ? Dir_M1 : Dir_M2), 64'(0));
            end
            beats++;
         end
         stalled_prev = out_valid && !out_ready;
         snap         = cur;
      end
      if (done) begin
         done_cnt++;
         done_t = $time;
      end
   end

   task automatic check_idle(input string name);
      check(name, 64'({Dir_M1, Dir_M2, out_valid, out_real, out_imag, out_row, out_col,
                       out_last, busy, done}), 64'(0));
   endtask

   task automatic push_matrix(input bit bank);
      logic [WORD_LEN-1:0] re, im;
      logic [IDX_W-1:0]    r, c;
      for (int n = 0; n < N_EL; n++) begin
         re = bank ? m2_re[n] : m1_re[n];
         im = bank ? m2_im[n] : m1_im[n];
         r  = IDX_W'(n / MATRIX_DIM);
         c  = IDX_W'(n % MATRIX_DIM);
         exp_q.push_back({re, im, r, c, (n == N_EL - 1)});
      end
   endtask

   task automatic issue_start(input bit bank, output time t_acc);
      @(posedge clk);
      #1;
      exp_bank   = bank;
      seen_valid = 1'b0;
      beats      = 0;
      start      = 1'b1;
      bank_sel   = bank;
      @(posedge clk);
      t_acc = $time;
      #1;
      start    = 1'b0;
      bank_sel = ~bank;
   endtask

   task automatic wait_done(input int bound);
      int d;
      d = done_cnt;
      for (int i = 0; i < bound && done_cnt == d; i++) begin
         @(negedge clk);
         #1;
      end
      check("done_seen", 64'(done_cnt - d), 64'(1));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
      #1;
      check("done_one_cycle", 64'({done, busy}), 64'(0));
   endtask

   task automatic wait_beats(input int n, input int bound);
      for (int i = 0; i < bound && beats < n; i++) begin
         @(negedge clk);
         #1;
      end
      check("beat_wait", 64'(beats >= n), 64'(1));
   endtask

   task automatic full_read_timed(input string tag);
      push_matrix(1'b0);
      issue_start(1'b0, t0);
      wait_done(300);
      check({tag, "_first_valid"}, 64'(first_valid_t - t0), 64'(2 * 10 + 5));
      check({tag, "_start_to_done"}, 64'(done_t - t0), 64'(MATRIX_DIM * (MATRIX_DIM + 2) * 10 + 5));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; bank_sel = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < N_EL; k++) begin
         m1_re[k] = WORD_LEN'(k);
         m1_im[k] = WORD_LEN'(16'h100 + k);
         m2_re[k] = WORD_LEN'(16'h200 + k);
         m2_im[k] = WORD_LEN'(16'h300 + k);
      end
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset_state");
      rst = 1'b0;

      // Full-throughput M1 read with latency checks.
      full_read_timed("m1");

      // M2 read: unselected M1 address must stay 0 on every beat.
      push_matrix(1'b1);
      issue_start(1'b1, t0);
      wait_done(300);

      // Random backpressure.
      rnd_ready = 1'b1;
      push_matrix(1'b0);
      issue_start(1'b0, t0);
      wait_done(3000);
      rnd_ready = 1'b0;

      // Start pulse during row 3 is ignored.
      push_matrix(1'b0);
      d0 = done_cnt;
      issue_start(1'b0, t0);
      wait_beats(3 * MATRIX_DIM + 2, 300);
      @(posedge clk); #1; start = 1'b1; bank_sel = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(300);
      repeat (10) @(negedge clk);
      check("single_done", 64'(done_cnt), 64'(d0 + 1));

      // Abort at beat 20, then abort+start together in IDLE, then restart.
      push_matrix(1'b0);
      issue_start(1'b0, t0);
      wait_beats(20, 300);
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      check_idle("abort_idle");
      exp_q.delete();
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      check("abort_no_done", 64'(done_cnt), 64'(d0));
      @(posedge clk); #1; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
      check("abort_beats_start", 64'({busy, out_valid}), 64'(0));
      push_matrix(1'b0);
      issue_start(1'b0, t0);
      wait_done(300);

      // Reset at beat 40, then an identical full read.
      rnd_ready = 1'b1;
      push_matrix(1'b0);
      issue_start(1'b0, t0);
      wait_beats(40, 1000);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      check_idle("rst_idle");
      exp_q.delete();
      rnd_ready = 1'b0;
      full_read_timed("after_rst");

      // Random matrix contents, random bank, random backpressure.
      rnd_ready = 1'b1;
      for (int it = 0; it < 4; it++) begin
         bit b;
         for (int k = 0; k < N_EL; k++) begin
            m1_re[k] = WORD_LEN'($urandom); m1_im[k] = WORD_LEN'($urandom);
            m2_re[k] = WORD_LEN'($urandom); m2_im[k] = WORD_LEN'($urandom);
         end
         b = 1'($urandom_range(0, 1));
         push_matrix(b);
         issue_start(b, t0);
         wait_done(3000);
      end
      rnd_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
